// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile_pkg
// Brief  : Shared constants for the Y86-64 write-back stage: status codes,
//          the RNONE register ID, instruction codes, FSM state encoding and
//          a helper that maps a W-stage status to the code latched on stop.
// Rev    : 1.0  initial release
// ============================================================================
package wb_regfile_pkg;

    // Processor status codes
    localparam logic [2:0] c_SBUB = 3'd0;
    localparam logic [2:0] c_SAOK = 3'd1;
    localparam logic [2:0] c_SHLT = 3'd2;
    localparam logic [2:0] c_SADR = 3'd3;
    localparam logic [2:0] c_SINS = 3'd4;

    // Register ID meaning "no register"
    localparam logic [3:0] c_RNONE = 4'hF;

    // Instruction codes
    localparam logic [3:0] c_IHALT   = 4'h0;
    localparam logic [3:0] c_INOP    = 4'h1;
    localparam logic [3:0] c_IRRMOVQ = 4'h2;
    localparam logic [3:0] c_IIRMOVQ = 4'h3;
    localparam logic [3:0] c_IRMMOVQ = 4'h4;
    localparam logic [3:0] c_IMRMOVQ = 4'h5;
    localparam logic [3:0] c_IOPQ    = 4'h6;
    localparam logic [3:0] c_IJXX    = 4'h7;
    localparam logic [3:0] c_ICALL   = 4'h8;
    localparam logic [3:0] c_IRET    = 4'h9;
    localparam logic [3:0] c_IPUSHQ  = 4'hA;
    localparam logic [3:0] c_IPOPQ   = 4'hB;

    // FSM state encoding
    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HALT = 1'b1;

    // Status code recorded when the machine stops: HLT/ADR/INS are kept as-is,
    // any undefined code (5..7) is reported as an invalid instruction.
    function automatic logic [2:0] stop_code(input logic [2:0] code);
        if (code == c_SHLT || code == c_SADR || code == c_SINS)
            return code;
        else
            return c_SINS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_regfile_rf_array.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile_rf_array
// Brief  : NREG x DATA_W register storage with two synchronous write ports
//          (port M has priority over port E on the same ID), two purely
//          combinational read ports (IDs outside 0..NREG-1 read as zero) and
//          an asynchronous clear.
// Ports  : clk, rst            clock / async active-high clear
//          i_we_e/i_addr_e/i_data_e   write port E
//          i_we_m/i_addr_m/i_data_m   write port M (wins on collision)
//          i_src_a/i_src_b     read IDs
//          o_rval_a/o_rval_b   read data
// Rev    : 1.0  initial release
// ============================================================================
module wb_regfile_rf_array #(
    parameter int NREG   = 15,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we_e,
    input  logic [3:0]        i_addr_e,
    input  logic [DATA_W-1:0] i_data_e,
    input  logic              i_we_m,
    input  logic [3:0]        i_addr_m,
    input  logic [DATA_W-1:0] i_data_m,
    input  logic [3:0]        i_src_a,
    input  logic [3:0]        i_src_b,
    output logic [DATA_W-1:0] o_rval_a,
    output logic [DATA_W-1:0] o_rval_b
);

    logic [DATA_W-1:0] r_regs [NREG];

    // One flop bank per register; each bank decodes its own ID so no array
    // index can ever fall outside the storage.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        localparam logic [3:0] c_ID = 4'(gi);
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_regs[gi] <= '0;
            else if (i_we_m && i_addr_m == c_ID)
                r_regs[gi] <= i_data_m;
            else if (i_we_e && i_addr_e == c_ID)
                r_regs[gi] <= i_data_e;
        end
    end

    // Read muxes: unmatched IDs (including RNONE) fall through to zero.
    always_comb begin
        o_rval_a = '0;
        o_rval_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i_src_a == 4'(i)) o_rval_a = r_regs[i];
            if (i_src_b == 4'(i)) o_rval_b = r_regs[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile
// Brief  : Y86-64 write-back stage. Commits W-stage results into the register
//          file, serves the two decode read ports, tracks processor status
//          (sticky halt) and counts retired instructions.
// Ports  : clk, rst                  clock / async active-high reset
//          w_stat, w_icode           W-stage status and instruction code
//          w_dstE, w_valE            ALU result destination / value
//          w_dstM, w_valM            memory result destination / value
//          d_srcA, d_srcB            decode read IDs
//          d_rvalA, d_rvalB          decode read data (0 for RNONE)
//          stat, halted              processor status / stopped flag
//          retired                   committed AOK instruction count
// Rev    : 1.0  initial release
// ============================================================================
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int NREG  = 15,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       w_stat,
    input  logic [3:0]       w_icode,
    input  logic [3:0]       w_dstE,
    input  logic [3:0]       w_dstM,
    input  logic [63:0]      w_valE,
    input  logic [63:0]      w_valM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [2:0]       r_stat;
    logic [2:0]       w_stat_nxt;
    logic [CNT_W-1:0] r_retired;
    logic             w_commit;
    logic             w_we_e;
    logic             w_we_m;

    // The instruction code carries no information the commit logic needs;
    // it is folded here so the port is visibly consumed.
    logic w_unused_icode;
    assign w_unused_icode = ^w_icode;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_RUN;
            r_stat    <= c_SAOK;
            r_retired <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stat  <= w_stat_nxt;
            if (w_commit)
                r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stat_nxt  = r_stat;
        w_commit    = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (w_stat == c_SAOK) begin
                    w_commit = 1'b1;
                end else if (w_stat != c_SBUB) begin
                    // Stopping instruction: record its code, commit nothing.
                    w_state_nxt = c_ST_HALT;
                    w_stat_nxt  = stop_code(w_stat);
                end
            end
            default: begin
                // HALT is terminal until reset.
                w_state_nxt = c_ST_HALT;
            end
        endcase
    end

    assign w_we_e = w_commit && (w_dstE != c_RNONE);
    assign w_we_m = w_commit && (w_dstM != c_RNONE);

    // ---------------------------------------------------------- register file
    wb_regfile_rf_array #(
        .NREG   (NREG),
        .DATA_W (64)
    ) u_rf_array (
        .clk      (clk),
        .rst      (rst),
        .i_we_e   (w_we_e),
        .i_addr_e (w_dstE),
        .i_data_e (w_valE),
        .i_we_m   (w_we_m),
        .i_addr_m (w_dstM),
        .i_data_m (w_valM),
        .i_src_a  (d_srcA),
        .i_src_b  (d_srcB),
        .o_rval_a (d_rvalA),
        .o_rval_b (d_rvalB)
    );

    assign stat    = r_stat;
    assign halted  = (r_state == c_ST_HALT);
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_regfile
// Brief  : Self-checking bench for wb_regfile: table of directed W-stage
//          vectors with hand-computed expected reads/status, plus sequences
//          for asynchronous reset, write latency, undefined stop codes and
//          counter wrap (counter built 4 bits wide).
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_regfile;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [2:0]       w_stat;
    logic [3:0]       w_icode;
    logic [3:0]       w_dstE;
    logic [3:0]       w_dstM;
    logic [63:0]      w_valE;
    logic [63:0]      w_valM;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [63:0]      d_rvalA;
    logic [63:0]      d_rvalB;
    logic [2:0]       stat;
    logic             halted;
    logic [CNT_W-1:0] retired;

    int total = 0;
    int bad   = 0;

    wb_regfile #(
        .NREG  (15),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .w_stat  (w_stat),
        .w_icode (w_icode),
        .w_dstE  (w_dstE),
        .w_dstM  (w_dstM),
        .w_valE  (w_valE),
        .w_valM  (w_valM),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .d_rvalA (d_rvalA),
        .d_rvalB (d_rvalB),
        .stat    (stat),
        .halted  (halted),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic [3:0]  de;
        logic [3:0]  dm;
        logic [63:0] ve;
        logic [63:0] vm;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [3:0]  eret;
        logic [2:0]  estat;
        logic        ehalt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        w_stat = st;
        w_dstE = de;
        w_valE = ve;
        w_dstM = dm;
        w_valM = vm;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // stat dE dM valE valM srcA srcB expA expB ret stat halt
        vecs[0] = '{3'd1, 4'h0, 4'hF, 64'h1234, 64'h0,   4'h0, 4'hF, 64'h1234, 64'h0,    4'd1, 3'd1, 1'b0};
        vecs[1] = '{3'd1, 4'h4, 4'h4, 64'h8,    64'hAA,  4'h4, 4'h0, 64'hAA,   64'h1234, 4'd2, 3'd1, 1'b0};
        vecs[2] = '{3'd0, 4'h1, 4'hF, 64'h5,    64'h0,   4'h1, 4'h4, 64'h0,    64'hAA,   4'd2, 3'd1, 1'b0};
        vecs[3] = '{3'd1, 4'h1, 4'h3, 64'h5,    64'h77,  4'h1, 4'h3, 64'h5,    64'h77,   4'd3, 3'd1, 1'b0};
        vecs[4] = '{3'd1, 4'hF, 4'hF, 64'h0,    64'h0,   4'h0, 4'hF, 64'h1234, 64'h0,    4'd4, 3'd1, 1'b0};
        vecs[5] = '{3'd1, 4'hE, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h9, 4'hE, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h9, 4'd5, 3'd1, 1'b0};
        vecs[6] = '{3'd1, 4'h3, 4'h3, 64'h1,    64'h2,   4'hF, 4'h3, 64'h0,    64'h2,    4'd6, 3'd1, 1'b0};
        vecs[7] = '{3'd3, 4'h2, 4'hF, 64'h7,    64'h0,   4'h2, 4'h3, 64'h0,    64'h2,    4'd6, 3'd3, 1'b1};
        vecs[8] = '{3'd1, 4'h2, 4'h1, 64'h7,    64'h99,  4'h2, 4'h1, 64'h0,    64'h5,    4'd6, 3'd3, 1'b1};
        vecs[9] = '{3'd2, 4'h0, 4'hF, 64'h0,    64'h0,   4'h0, 4'h4, 64'h9,    64'hAA,   4'd6, 3'd3, 1'b1};

        rst     = 1'b1;
        w_icode = 4'h1;
        d_srcA  = 4'h0;
        d_srcB  = 4'hE;
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset rA", d_rvalA, 64'h0);
        chk("reset rB", d_rvalB, 64'h0);
        chk("reset stat", 64'(stat), 64'd1);
        chk("reset halted", 64'(halted), 64'd0);
        chk("reset retired", 64'(retired), 64'd0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].st, vecs[i].de, vecs[i].ve, vecs[i].dm, vecs[i].vm);
            d_srcA = vecs[i].sa;
            d_srcB = vecs[i].sb;
            tick();
            #1;
            chk($sformatf("vec%0d rA", i), d_rvalA, vecs[i].ea);
            chk($sformatf("vec%0d rB", i), d_rvalB, vecs[i].eb);
            chk($sformatf("vec%0d retired", i), 64'(retired), 64'(vecs[i].eret));
            chk($sformatf("vec%0d stat", i), 64'(stat), 64'(vecs[i].estat));
            chk($sformatf("vec%0d halted", i), 64'(halted), 64'(vecs[i].ehalt));
        end

        // Asynchronous reset asserted mid-cycle takes effect at once.
        drive(3'd1, 4'h5, 64'h55, 4'hF, 64'h0);
        d_srcA = 4'h0;
        d_srcB = 4'h4;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst rA", d_rvalA, 64'h0);
        chk("async rst rB", d_rvalB, 64'h0);
        chk("async rst stat", 64'(stat), 64'd1);
        chk("async rst halted", 64'(halted), 64'd0);
        chk("async rst retired", 64'(retired), 64'd0);
        tick();
        rst = 1'b0;
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        tick();
        d_srcA = 4'h5;
        #1;
        chk("rst discards write", d_rvalA, 64'h0);

        // One-cycle write latency: not visible before the edge, visible after.
        drive(3'd1, 4'h5, 64'h55, 4'hF, 64'h0);
        #1;
        chk("pre-edge read", d_rvalA, 64'h0);
        tick();
        chk("post-edge read", d_rvalA, 64'h55);
        chk("latency retired", 64'(retired), 64'd1);

        // Undefined status code stops the machine, reported as INS.
        drive(3'd6, 4'h7, 64'h70, 4'hF, 64'h0);
        d_srcA = 4'h7;
        tick();
        chk("undef stat", 64'(stat), 64'd4);
        chk("undef halted", 64'(halted), 64'd1);
        chk("undef no write", d_rvalA, 64'h0);
        chk("undef retired", 64'(retired), 64'd1);

        // Counter wrap on a 4-bit counter.
        do_reset();
        drive(3'd1, 4'hF, 64'h0, 4'hF, 64'h0);
        for (int i = 0; i < 15; i++) tick();
        chk("cnt max", 64'(retired), 64'd15);
        tick();
        chk("cnt wrap", 64'(retired), 64'd0);
        d_srcA = 4'hF;
        d_srcB = 4'hF;
        #1;
        chk("rnone rA", d_rvalA, 64'h0);
        chk("rnone rB", d_rvalB, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
